// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch FIFO and the fetch_unit top.
package fetch_unit_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INST_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear, occupancy count and a combinational head output.
// DEPTH need not be a power of two; the pointers wrap explicitly.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH-1) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (resetn || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale entries are never observable and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches with a credit
// limit, buffers responses and hands {inst, pc+4} to decode; redirects flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INST_W     = DEF_INST_W,
  parameter int                FIFO_DEPTH = 4,
  parameter int                MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc_plus4
);

  localparam int OUT_W = $clog2(MAX_OUTST+1);
  localparam int BUF_W = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc_plus4;
  } buf_entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OUT_W-1:0]  drop_q, drop_d;

  logic [OUT_W-1:0]  outst, outst_nxt;
  logic [ADDR_W-1:0] tag_head;
  logic              tag_full, tag_empty;
  logic [BUF_W-1:0]  buf_count;
  logic              buf_full, buf_empty;
  buf_entry_t        buf_head, buf_in;

  logic req_hs, rsp_take, buf_push, buf_pop;

  // Credit rule: every outstanding request already owns a slot in the buffer.
  assign imem_req_valid = !resetn && (state_q == FETCH) && !tag_full &&
                          (int'(buf_count) + int'(outst) < FIFO_DEPTH);
  assign imem_req_addr  = pc_q;

  assign req_hs    = imem_req_valid && imem_req_ready;
  assign rsp_take  = !resetn && imem_rsp_valid && !tag_empty;
  assign buf_push  = rsp_take && (state_q == FETCH) && !redirect_valid && !buf_full;
  assign buf_pop   = out_valid && out_ready;
  assign outst_nxt = outst + OUT_W'(req_hs) - OUT_W'(rsp_take);

  assign buf_in.inst     = imem_rsp_data;
  assign buf_in.pc_plus4 = tag_head + ADDR_W'(4);

  // The tag queue count is the outstanding-request counter; it is never cleared
  // by a redirect so dropped responses still retire their tags in order.
  fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(ADDR_W)) u_tag_q (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (1'b0),
    .push_i  (req_hs),
    .data_i  (pc_q),
    .pop_i   (rsp_take),
    .head_o  (tag_head),
    .count_o (outst),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(buf_entry_t))) u_inst_buf (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (redirect_valid),
    .push_i  (buf_push),
    .data_i  (buf_in),
    .pop_i   (buf_pop),
    .head_o  (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (req_hs) pc_d = pc_q + ADDR_W'(4);
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~ADDR_W'(3);
      drop_d  = outst_nxt;
      state_d = (outst_nxt != '0) ? FLUSH : FETCH;
    end else if (state_q == FLUSH && rsp_take) begin
      drop_d = drop_q - OUT_W'(1);
      if (drop_q == OUT_W'(1)) state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid    = !buf_empty;
  assign out_inst     = buf_empty ? INST_W'(NOP_INST) : buf_head.inst;
  assign out_pc_plus4 = buf_empty ? '0 : buf_head.pc_plus4;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that drives the CPU's IF/ID boundary. It owns the PC, issues word fetches to a variable-latency instruction memory over a valid/ready request port with in-order responses, and buffers returned instructions in a small FIFO. It presents {instruction, PC+4} to decode through a valid/ready handshake. On a taken-branch redirect it flushes the FIFO and discards in-flight responses.

Parameters:
ADDR_W, 32, PC and memory address width
INST_W, 32, instruction width
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUTST, 2, maximum un-returned memory requests (>=1)
RESET_PC, 32'h0, PC value after reset

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous reset, active-high (asserted = 1), sampled on rising clk
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  byte address of fetch, bits [1:0] always 0
imem_rsp_valid  in  1  response data valid; responses return in request order, never back-pressured
imem_rsp_data  in  INST_W  fetched instruction
redirect_valid  in  1  taken branch: restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (treated as 00)
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts (deasserted = stall)
out_inst  out  INST_W  FIFO head instruction
out_pc_plus4  out  ADDR_W  fetch address of head + 4

Behaviour:
- Reset (resetn=1 at edge): pc=RESET_PC, FIFO empty, outst=0, drop_cnt=0, state=FETCH; imem_req_valid=0, out_valid=0, out_inst=0, out_pc_plus4=0. Reset mid-operation: same; responses arriving in the first cycle after reset are ignored (drop_cnt is not preserved).
- States: FETCH, FLUSH.
- FETCH: imem_req_valid=1 when outst < MAX_OUTST and (fifo_count + outst) < FIFO_DEPTH (space reserved for every outstanding response). imem_req_addr=pc. On req handshake: pc <= pc+4 (wraps modulo 2^ADDR_W), outst++, and the address is pushed to an internal tag queue so the matching response is written with its PC+4.
- Response with drop_cnt=0: write {data, addr+4} to FIFO tail, outst--. Simultaneous request and response: outst unchanged.
- Output: out_valid = FIFO non-empty; pop on out_valid & out_ready. Simultaneous push and pop when full is impossible by credit rule; push and pop on same cycle at any other count both take effect.
- Latency: request accepted cycle N, response cycle N+k; out_valid high from cycle N+k+1 (FIFO registered, no bypass).
- Redirect (highest priority, any state): FIFO cleared, out_valid=0 next cycle, pc <= {redirect_pc[ADDR_W-1:2],2'b00}. drop_cnt <= outst + (req handshake this cycle) − (response this cycle); response arriving in the redirect cycle is discarded. If resulting drop_cnt>0 go FLUSH, else FETCH. Pop on the redirect cycle is still honoured by decode but FIFO is cleared regardless.
- FLUSH: imem_req_valid=0; each response discarded, drop_cnt--, outst--; return to FETCH in the cycle after drop_cnt reaches 0. A second redirect in FLUSH reloads pc and recomputes drop_cnt by the same rule.
- Redirect with outst=0 and no handshake: stays FETCH; first request at new pc the next cycle.
- imem_rsp_valid with outst=0 (protocol error): ignored, counters do not underflow.

Decomposition:
- Shared package: ADDR_W/INST_W defaults, RESET_PC, NOP encoding 32'h0, fetch state encoding (FETCH, FLUSH).
- One sub-module: fetch_fifo (parameterised sync FIFO, push/pop/clear, count, full/empty), instantiated twice: tag queue (depth MAX_OUTST, ADDR_W) and instruction buffer (FIFO_DEPTH, INST_W+ADDR_W).

Test Plan:
- Reset, memory always ready, latency 1, out_ready=1 -> requests at 0x0,0x4,0x8…; out_inst sequence matches memory, out_pc_plus4 = 0x4,0x8,0xC; steady one instruction per cycle.
- out_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 responses buffered, no further requests once (count+outst)=4; release -> 4 instructions in order, no loss or duplication.
- imem_req_ready toggling, latency 3 -> outst never exceeds 2; order preserved; throughput limited, no bubble-induced reordering.
- Two requests outstanding (0x10,0x14), redirect_pc=0x103 -> both responses dropped, state FLUSH 2 cycles, next request addr 0x100, first out_pc_plus4=0x104.
- Redirect in the same cycle as a request handshake and a response -> response discarded, drop_cnt counts new request; no stale instruction reaches output.
- pc=0xFFFFFFFC fetch -> next addr 0x0, out_pc_plus4=0x0; resetn asserted with 2 outstanding -> outputs zero next cycle, pc=RESET_PC.
